// File: rtl/cpu_fetch_ctrl.sv
// Instruction-fetch sequencer: reads three-word instructions over a word-read
// handshake, strobes the exec unit, and owns the architectural PC and retire count.
module cpu_fetch_ctrl #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] STEP     = WIDTH'(12),
    parameter int unsigned      TIMEOUT  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    output logic             mem_req_o,
    output logic [WIDTH-1:0] mem_addr_o,
    input  logic             mem_ack_i,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic [WIDTH-1:0] opcode_o,
    output logic [WIDTH-1:0] opa_o,
    output logic [WIDTH-1:0] opb_o,
    output logic             exec_en_o,
    output logic             fetch_done_o,
    input  logic             exec_done_i,
    input  logic [WIDTH-1:0] newpc_i,
    input  logic             isjcc_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [WIDTH-1:0] retired_o
);

    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned WORD_B = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DISPATCH,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [WIDTH-1:0]  next_pc;

    // Program counter after the instruction now retiring.
    always_comb begin
        next_pc = pc_o + STEP;
        if (isjcc_i) begin
            next_pc = newpc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            idx          <= '0;
            tmo_cnt      <= '0;
            pc_o         <= RESET_PC;
            mem_addr_o   <= RESET_PC;
            mem_req_o    <= 1'b0;
            opcode_o     <= '0;
            opa_o        <= '0;
            opb_o        <= '0;
            exec_en_o    <= 1'b0;
            fetch_done_o <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
            retired_o    <= '0;
        end else begin
            fetch_done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run_i) begin
                        state      <= S_FETCH;
                        idx        <= '0;
                        tmo_cnt    <= '0;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= pc_o;
                        busy_o     <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (mem_ack_i) begin
                        case (idx)
                            IDX_W'(0): opcode_o <= mem_rdata_i;
                            IDX_W'(1): opa_o    <= mem_rdata_i;
                            default:   opb_o    <= mem_rdata_i;
                        endcase
                        tmo_cnt <= '0;
                        if (idx == IDX_W'(2)) begin
                            // Operands are registered here, so the strobe lands with them.
                            state        <= S_DISPATCH;
                            idx          <= '0;
                            mem_req_o    <= 1'b0;
                            fetch_done_o <= 1'b1;
                            exec_en_o    <= 1'b1;
                        end else begin
                            idx        <= idx + IDX_W'(1);
                            mem_addr_o <= mem_addr_o + WIDTH'(WORD_B);
                        end
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        state     <= S_HALT;
                        err_o     <= 1'b1;
                        mem_req_o <= 1'b0;
                        busy_o    <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                S_DISPATCH: begin
                    state <= S_EXEC;
                end

                S_EXEC: begin
                    if (exec_done_i) begin
                        state     <= S_UPDATE;
                        exec_en_o <= 1'b0;
                    end
                end

                S_UPDATE: begin
                    pc_o      <= next_pc;
                    retired_o <= retired_o + WIDTH'(1);
                    if (run_i) begin
                        state      <= S_FETCH;
                        idx        <= '0;
                        tmo_cnt    <= '0;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= next_pc;
                    end else begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end
                end

                S_HALT: begin
                    state <= S_HALT;
                end

                default: begin
                    state     <= S_IDLE;
                    mem_req_o <= 1'b0;
                    exec_en_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// Bench for cpu_fetch_ctrl: behavioural memory and exec-unit responders plus a
// transaction-level program model that predicts addresses, operands and PCs.
module tb_cpu_fetch_ctrl;

    localparam logic [31:0] OP_ADD = 32'h0000_0001;
    localparam logic [31:0] OP_SUB = 32'h0000_0002;
    localparam logic [31:0] OP_MUL = 32'h0000_0003;
    localparam logic [31:0] OP_JMP = 32'h0000_0004;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        run_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] opcode_o, opa_o, opb_o;
    logic        exec_en_o, fetch_done_o;
    logic        exec_done_i;
    logic [31:0] newpc_i;
    logic        isjcc_i;
    logic [31:0] pc_o;
    logic        busy_o, err_o;
    logic [31:0] retired_o;

    cpu_fetch_ctrl #(
        .WIDTH(32), .RESET_PC(32'h0), .STEP(32'hC), .TIMEOUT(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .opcode_o(opcode_o), .opa_o(opa_o), .opb_o(opb_o),
        .exec_en_o(exec_en_o), .fetch_done_o(fetch_done_o), .exec_done_i(exec_done_i),
        .newpc_i(newpc_i), .isjcc_i(isjcc_i), .pc_o(pc_o), .busy_o(busy_o),
        .err_o(err_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    // Environment: word memory with programmable ack latency, and an exec unit.
    logic [31:0] mem [256];
    int          ack_lat   = 0;
    int          cur_lat   = 0;
    bit          rand_lat  = 1'b0;
    int          wait_cnt  = 0;
    int          exec_lat  = 0;
    int          exec_cnt  = 0;
    bit          block_en  = 1'b0;
    logic [31:0] block_addr = 32'h0;
    bit          ack_force = 1'b0;
    int          lat_now;

    assign lat_now     = rand_lat ? cur_lat : ack_lat;
    assign mem_ack_i   = ack_force ||
                         (mem_req_o && (wait_cnt >= lat_now) && !(block_en && mem_addr_o == block_addr));
    assign mem_rdata_i = mem[mem_addr_o[9:2]];
    assign exec_done_i = exec_en_o && (exec_cnt >= exec_lat);
    assign isjcc_i     = (opcode_o == OP_JMP);
    assign newpc_i     = opa_o;

    always @(posedge clk_i) begin
        if (mem_req_o && !mem_ack_i) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
        if (mem_ack_i) cur_lat <= int'($urandom_range(0, 3));
        exec_cnt <= exec_en_o ? exec_cnt + 1 : 0;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    // Architectural rule: a jump goes to opa, anything else steps 12 bytes.
    function automatic logic [31:0] model_next(input logic [31:0] p);
        return (rd(p) == OP_JMP) ? rd(p + 32'd4) : p + 32'd12;
    endfunction

    // Program-level monitor.
    bit          mon_en    = 1'b0;
    logic [31:0] model_pc  = 32'h0;
    logic [31:0] model_ret = 32'h0;
    logic [31:0] prev_ret  = 32'h0;
    int          word_k    = 0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    bit          prev_fd   = 1'b0;
    int          fd_count  = 0;

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (retired_o != prev_ret) begin
                model_pc  = model_next(model_pc);
                model_ret = model_ret + 32'd1;
                check("ret_count", retired_o, model_ret);
                check("ret_pc", pc_o, model_pc);
                prev_ret = retired_o;
            end
            if (mem_req_o && prev_wait) check("addr_hold", mem_addr_o, prev_addr);
            if (mem_req_o && mem_ack_i) begin
                check("fetch_addr", mem_addr_o, model_pc + 32'(4 * word_k));
                word_k++;
            end
            prev_wait = mem_req_o && !mem_ack_i;
            prev_addr = mem_addr_o;
            if (fetch_done_o) begin
                fd_count++;
                check("fd_single", 32'(prev_fd), 32'd0);
                check("fd_words", 32'(word_k), 32'd3);
                check("fd_pc", pc_o, model_pc);
                check("fd_opcode", opcode_o, rd(model_pc));
                check("fd_opa", opa_o, rd(model_pc + 32'd4));
                check("fd_opb", opb_o, rd(model_pc + 32'd8));
                check("fd_exec_en", 32'(exec_en_o), 32'd1);
                check("fd_req_low", 32'(mem_req_o), 32'd0);
                check("fd_busy", 32'(busy_o), 32'd1);
                word_k = 0;
            end
            prev_fd = fetch_done_o;
        end
    end

    task automatic do_reset();
        mon_en    = 1'b0;
        run_i     = 1'b0;
        ack_force = 1'b0;
        rst_i     = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i     = 1'b0;
        model_pc  = 32'h0;
        model_ret = 32'h0;
        prev_ret  = 32'h0;
        word_k    = 0;
        prev_wait = 1'b0;
        prev_fd   = 1'b0;
        fd_count  = 0;
        mon_en    = 1'b1;
    endtask

    task automatic wait_ret(input logic [31:0] n, input string name);
        int c = 0;
        while (retired_o != n && c < 1000) begin
            @(negedge clk_i);
            c++;
        end
        check(name, retired_o, n);
    endtask

    task automatic load_linear();
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = OP_ADD;
        mem[3] = OP_SUB;
        mem[6] = OP_MUL;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, pc_o, 32'h0);
        check({tag, "_opcode"}, opcode_o, 32'h0);
        check({tag, "_opa"}, opa_o, 32'h0);
        check({tag, "_opb"}, opb_o, 32'h0);
        check({tag, "_retired"}, retired_o, 32'h0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
        check({tag, "_req"}, 32'(mem_req_o), 32'd0);
        check({tag, "_fd"}, 32'(fetch_done_o), 32'd0);
        check({tag, "_exec_en"}, 32'(exec_en_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    typedef struct {
        int          ack_lat;
        int          exec_lat;
        logic [31:0] n_instr;
        logic [31:0] exp_pc;
        int          exp_cycles;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int c;
        int cnt;

        // cycles = 1 (IDLE->FETCH) + n * (3*(lat+1) + 1 + max(1,exec) + 1)
        tbl[0] = '{ack_lat: 0, exec_lat: 0, n_instr: 32'd3, exp_pc: 32'h24, exp_cycles: 19};
        tbl[1] = '{ack_lat: 2, exec_lat: 0, n_instr: 32'd2, exp_pc: 32'h18, exp_cycles: 25};
        tbl[2] = '{ack_lat: 1, exec_lat: 3, n_instr: 32'd2, exp_pc: 32'h18, exp_cycles: 23};
        tbl[3] = '{ack_lat: 0, exec_lat: 1, n_instr: 32'd4, exp_pc: 32'h30, exp_cycles: 25};

        load_linear();
        do_reset();
        check_reset_outputs("rst");

        // Straight-line program under several memory/exec latencies.
        for (int i = 0; i < 4; i++) begin
            load_linear();
            ack_lat  = tbl[i].ack_lat;
            exec_lat = tbl[i].exec_lat;
            do_reset();
            run_i = 1'b1;
            c = 0;
            while (retired_o != tbl[i].n_instr && c < 500) begin
                @(negedge clk_i);
                c++;
            end
            check("tbl_cycles", 32'(c), 32'(tbl[i].exp_cycles));
            check("tbl_retired", retired_o, tbl[i].n_instr);
            check("tbl_pc", pc_o, tbl[i].exp_pc);
        end

        // Jump at 0xC redirects the next fetch to 0x30.
        load_linear();
        mem[3] = OP_JMP;
        mem[4] = 32'h30;
        ack_lat = 0; exec_lat = 0;
        do_reset();
        run_i = 1'b1;
        wait_ret(32'd2, "jmp_wait");
        check("jmp_pc", pc_o, 32'h30);
        check("jmp_req", 32'(mem_req_o), 32'd1);
        check("jmp_addr", mem_addr_o, 32'h30);

        // Dropping run mid-fetch lets the instruction finish, then parks in IDLE.
        load_linear();
        do_reset();
        run_i = 1'b1;
        c = 0;
        while (!(mem_req_o && mem_addr_o == 32'h4) && c < 50) begin
            @(negedge clk_i);
            c++;
        end
        check("drop_reach_opa", mem_addr_o, 32'h4);
        run_i = 1'b0;
        wait_ret(32'd1, "drop_wait");
        repeat (3) @(negedge clk_i);
        check("drop_pc", pc_o, 32'hC);
        check("drop_retired", retired_o, 32'd1);
        check("drop_req", 32'(mem_req_o), 32'd0);
        check("drop_busy", 32'(busy_o), 32'd0);
        run_i = 1'b1;
        @(negedge clk_i);
        check("resume_req", 32'(mem_req_o), 32'd1);
        check("resume_addr", mem_addr_o, 32'hC);
        wait_ret(32'd2, "resume_wait");
        check("resume_pc", pc_o, 32'h18);

        // Jump past the top of the address space wraps PC to zero; jump to self refetches.
        load_linear();
        mem[0]   = OP_JMP;
        mem[1]   = 32'hFFFF_FFF4;
        mem[253] = OP_ADD;
        do_reset();
        run_i = 1'b1;
        wait_ret(32'd1, "wrap_wait1");
        check("wrap_pc_hi", pc_o, 32'hFFFF_FFF4);
        wait_ret(32'd2, "wrap_wait2");
        check("wrap_pc_zero", pc_o, 32'h0);
        load_linear();
        mem[0] = OP_JMP;
        mem[1] = 32'h0;
        do_reset();
        run_i = 1'b1;
        wait_ret(32'd2, "self_wait");
        check("self_pc", pc_o, 32'h0);

        // Word at 0x4 never acknowledged: timeout into HALT.
        load_linear();
        block_en = 1'b1; block_addr = 32'h4;
        do_reset();
        run_i = 1'b1;
        c = 0; cnt = 0;
        while (!err_o && c < 200) begin
            @(negedge clk_i);
            c++;
            if (mem_req_o && mem_addr_o == 32'h4) cnt++;
        end
        check("tmo_req_cycles", 32'(cnt), 32'd16);
        check("tmo_err", 32'(err_o), 32'd1);
        repeat (20) @(negedge clk_i);
        check("halt_err", 32'(err_o), 32'd1);
        check("halt_busy", 32'(busy_o), 32'd0);
        check("halt_req", 32'(mem_req_o), 32'd0);
        check("halt_no_fd", 32'(fd_count), 32'd0);
        check("halt_pc", pc_o, 32'h0);
        block_en = 1'b0;
        do_reset();
        check("halt_clr_err", 32'(err_o), 32'd0);

        // Reset mid-EXEC with a stray ack in the same cycle.
        load_linear();
        exec_lat = 5;
        do_reset();
        run_i = 1'b1;
        wait_ret(32'd1, "rexec_wait");
        c = 0;
        while (!(exec_en_o && !fetch_done_o) && c < 100) begin
            @(negedge clk_i);
            c++;
        end
        check("rexec_in_exec", 32'(exec_en_o), 32'd1);
        mon_en = 1'b0; rst_i = 1'b1; ack_force = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; ack_force = 1'b0; run_i = 1'b0;
        check_reset_outputs("rexec");

        // Reset mid-FETCH with the ack present: nothing captured.
        exec_lat = 0;
        do_reset();
        run_i = 1'b1;
        @(negedge clk_i);
        check("rfetch_ack_seen", 32'(mem_ack_i), 32'd1);
        mon_en = 1'b0; rst_i = 1'b1; run_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rfetch_opcode", opcode_o, 32'h0);
        check("rfetch_req", 32'(mem_req_o), 32'd0);
        check("rfetch_busy", 32'(busy_o), 32'd0);

        // Random programs, random latencies, run_i toggling freely.
        for (int e = 0; e < 4; e++) begin
            for (int i = 0; i < 256; i++)
                mem[i] = ($urandom_range(0, 3) == 0) ? OP_JMP : 32'($urandom());
            rand_lat = 1'b1;
            exec_lat = int'($urandom_range(0, 3));
            do_reset();
            c = 0;
            while (retired_o != 32'd20 && c < 3000) begin
                @(negedge clk_i);
                c++;
                run_i = ($urandom_range(0, 3) != 0);
            end
            check("rand_progress", retired_o, 32'd20);
        end
        rand_lat = 1'b0;
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
